// File: rtl/simple_fixed_point_unsigned_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-add multiplier.
// The master drives operands; the slave returns the product.
interface simple_fixed_point_unsigned_shift_add_multiplier_if #(
   parameter int WIDTH = 8
);
   logic             i_valid;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_ready;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_overflow;

   modport master (
      output i_valid, i_a, i_b,
      input  o_ready, o_valid, o_data, o_overflow
   );

   modport slave (
      input  i_valid, i_a, i_b,
      output o_ready, o_valid, o_data, o_overflow
   );
endinterface

// File: rtl/simple_fixed_point_unsigned_shift_add_multiplier.sv
// Sequential unsigned fixed-point multiplier: one shift-and-add step per clock,
// result = (a*b) >> FRAC, truncated and saturated to WIDTH bits.
module simple_fixed_point_unsigned_shift_add_multiplier #(
   parameter int WIDTH = 8,
   parameter int FRAC  = 4
) (
   input logic i_clk,
   input logic i_reset_n,
   simple_fixed_point_unsigned_shift_add_multiplier_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [2*WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_data;
   logic               r_overflow;

   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_last;
   logic               w_hi_nz;

   assign w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : '0);
   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   // Anything above the WIDTH result bits after dropping FRAC means saturation.
   assign w_hi_nz    = |(w_acc_next >> (FRAC + WIDTH));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.i_valid) w_state_next = S_RUN;
         S_RUN:   if (w_last)      w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_valid) begin
                  r_a_sh <= {{WIDTH{1'b0}}, bus.i_a};
                  r_b_sh <= bus.i_b;
                  r_acc  <= '0;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               r_acc  <= w_acc_next;
               r_a_sh <= r_a_sh << 1;
               r_b_sh <= r_b_sh >> 1;
               r_cnt  <= r_cnt + CW'(1);
               if (w_last) begin
                  r_overflow <= w_hi_nz;
                  r_data     <= w_hi_nz ? '1 : w_acc_next[FRAC +: WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_ready    = (r_state == S_IDLE);
   assign bus.o_valid    = (r_state == S_DONE);
   assign bus.o_data     = r_data;
   assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_simple_fixed_point_unsigned_shift_add_multiplier.sv
// Directed self-checking bench for the shift-add fixed-point multiplier (WIDTH=8, FRAC=4).
module tb_simple_fixed_point_unsigned_shift_add_multiplier;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   simple_fixed_point_unsigned_shift_add_multiplier_if #(.WIDTH(8)) bus ();

   simple_fixed_point_unsigned_shift_add_multiplier #(
      .WIDTH(8),
      .FRAC (4)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference for the streaming test: 9-bit {overflow, data}.
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = {8'h00, a} * {8'h00, b};
      if ((p >> 12) != 16'h0) return {1'b1, 8'hFF};
      return {1'b0, p[11:4]};
   endfunction

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_o);
      int lat;
      for (int i = 0; i < 20 && !bus.o_ready; i++) @(negedge clk);
      check({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_a     = a;
      bus.i_b     = b;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_a     = 8'hA5;
      bus.i_b     = 8'h5A;
      check({tag, "_busy"}, 32'(bus.o_ready), 32'd0);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.o_valid) break;
      end
      check({tag, "_lat"}, 32'(lat), 32'd8);
      check({tag, "_data"}, 32'(bus.o_data), 32'(exp_d));
      check({tag, "_ovf"}, 32'(bus.o_overflow), 32'(exp_o));
      check({tag, "_rdy_at_v"}, 32'(bus.o_ready), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_vpulse"}, 32'(bus.o_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(bus.o_ready), 32'd1);
   endtask

   logic [7:0] ta [7] = '{8'h28, 8'hF0, 8'h10, 8'h01, 8'h33, 8'hFF, 8'h0C};
   logic [7:0] tb [7] = '{8'h18, 8'h20, 8'hFF, 8'h01, 8'h44, 8'hFF, 8'h30};

   initial begin
      logic [8:0] q[$];
      logic [8:0] e;
      int last_v;
      int n_res;
      int n_v;

      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.o_ready), 32'd1);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(bus.o_ready), 32'd1);
      check("post_rst_valid", 32'(bus.o_valid), 32'd0);
      check("post_rst_data", 32'(bus.o_data), 32'h00);
      check("post_rst_ovf", 32'(bus.o_overflow), 32'd0);

      run_op("basic", 8'h28, 8'h18, 8'h3C, 1'b0);
      run_op("sat", 8'hF0, 8'h20, 8'hFF, 1'b1);

      // Asynchronous reset between edges must clear held outputs immediately.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_data", 32'(bus.o_data), 32'h00);
      check("async_ovf", 32'(bus.o_overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("exact_max", 8'h10, 8'hFF, 8'hFF, 1'b0);
      run_op("trunc", 8'h01, 8'h01, 8'h00, 1'b0);
      run_op("zero", 8'h00, 8'hFF, 8'h00, 1'b0);

      // Streaming with i_valid held high.
      last_v = -1;
      n_res  = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         bus.i_valid = 1'b1;
         bus.i_a     = ta[cyc % 7];
         bus.i_b     = tb[cyc % 7];
         if (bus.o_ready) q.push_back(model(ta[cyc % 7], tb[cyc % 7]));
         @(posedge clk);
         #1;
         if (bus.o_valid) begin
            n_res++;
            e = (q.size() > 0) ? q.pop_front() : 9'h1XX;
            check("strm_data", 32'(bus.o_data), 32'(e[7:0]));
            check("strm_ovf", 32'(bus.o_overflow), 32'(e[8]));
            if (last_v >= 0) check("strm_gap", 32'(cyc - last_v), 32'd10);
            last_v = cyc;
         end
      end
      bus.i_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) begin
            n_res++;
            e = (q.size() > 0) ? q.pop_front() : 9'h1XX;
            check("drain_data", 32'(bus.o_data), 32'(e[7:0]));
            check("drain_ovf", 32'(bus.o_overflow), 32'(e[8]));
         end
      end
      check("strm_count", 32'(n_res), 32'd4);
      check("strm_pending", 32'(q.size()), 32'd0);

      // Reset four edges into a run aborts it.
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_a     = 8'h28;
      bus.i_b     = 8'h18;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(bus.o_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_v = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.o_valid) n_v++;
      end
      check("abort_novalid", 32'(n_v), 32'd0);
      check("abort_idle", 32'(bus.o_ready), 32'd1);
      run_op("after_abort", 8'h28, 8'h18, 8'h3C, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
